// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared encodings and request-check helpers for data-memory access.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

    // Stores have no unsigned variants, so any func3[2]=1 store is illegal.
    function automatic logic f3_illegal(input logic [2:0] func3, input logic we);
        logic bad;
        bad = 1'b0;
        case (func3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = we;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (func3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_load_align
// Brief    : Shifts a read word to the addressed lane and sign/zero-extends it.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] ld_data
);

    logic [31:0] w_shifted;

    assign w_shifted = word >> {addr_lo, 3'b000};

    always_comb begin
        ld_data = w_shifted;
        case (func3)
            F3_B:    ld_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
            F3_H:    ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   ld_data = {24'h000000, w_shifted[7:0]};
            F3_HU:   ld_data = {16'h0000,   w_shifted[15:0]};
            default: ld_data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Brief    : MEM-stage load/store sequencer for a data bus with wait states.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [2:0]  mem_func3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        exc_valid,
    output logic [1:0]  exc_code,
    output logic [31:0] exc_addr,
    output logic        dbus_req,
    output logic [3:0]  dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ready
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    state_t            r_state,      w_state;
    logic [31:0]       r_addr,       w_addr;
    logic [2:0]        r_func3,      w_func3;
    logic              r_we,         w_we;
    logic [CNT_W-1:0]  r_cnt,        w_cnt;
    logic              r_dbus_req,   w_dbus_req;
    logic [3:0]        r_dbus_we,    w_dbus_we;
    logic [31:0]       r_dbus_addr,  w_dbus_addr;
    logic [31:0]       r_dbus_wdata, w_dbus_wdata;
    logic [31:0]       r_ld_data,    w_ld_data;
    logic              r_ld_valid,   w_ld_valid;
    logic              r_exc_valid,  w_exc_valid;
    logic [1:0]        r_exc_code,   w_exc_code;
    logic [31:0]       r_exc_addr,   w_exc_addr;

    logic [31:0]       w_aligned;
    logic [3:0]        w_be;
    logic [31:0]       w_repl;

    dmem_load_align u_load_align (
        .func3   (r_func3),
        .addr_lo (r_addr[1:0]),
        .word    (dbus_rdata),
        .ld_data (w_aligned)
    );

    // Lane enables and replicated data; only legal store widths reach the bus.
    always_comb begin
        w_be   = 4'b1111;
        w_repl = mem_wdata;
        case (mem_func3)
            F3_B: begin
                w_be   = 4'b0001 << mem_addr[1:0];
                w_repl = {4{mem_wdata[7:0]}};
            end
            F3_H: begin
                w_be   = 4'b0011 << mem_addr[1:0];
                w_repl = {2{mem_wdata[15:0]}};
            end
            default: begin
                w_be   = 4'b1111;
                w_repl = mem_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_func3      <= '0;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            r_dbus_req   <= 1'b0;
            r_dbus_we    <= '0;
            r_dbus_addr  <= '0;
            r_dbus_wdata <= '0;
            r_ld_data    <= '0;
            r_ld_valid   <= 1'b0;
            r_exc_valid  <= 1'b0;
            r_exc_code   <= '0;
            r_exc_addr   <= '0;
        end else begin
            r_state      <= w_state;
            r_addr       <= w_addr;
            r_func3      <= w_func3;
            r_we         <= w_we;
            r_cnt        <= w_cnt;
            r_dbus_req   <= w_dbus_req;
            r_dbus_we    <= w_dbus_we;
            r_dbus_addr  <= w_dbus_addr;
            r_dbus_wdata <= w_dbus_wdata;
            r_ld_data    <= w_ld_data;
            r_ld_valid   <= w_ld_valid;
            r_exc_valid  <= w_exc_valid;
            r_exc_code   <= w_exc_code;
            r_exc_addr   <= w_exc_addr;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_addr       = r_addr;
        w_func3      = r_func3;
        w_we         = r_we;
        w_cnt        = r_cnt;
        w_dbus_req   = r_dbus_req;
        w_dbus_we    = r_dbus_we;
        w_dbus_addr  = r_dbus_addr;
        w_dbus_wdata = r_dbus_wdata;
        w_ld_data    = r_ld_data;
        w_ld_valid   = 1'b0;
        w_exc_valid  = 1'b0;
        w_exc_code   = r_exc_code;
        w_exc_addr   = r_exc_addr;

        case (r_state)
            ST_IDLE: begin
                if (mem_req) begin
                    w_addr  = mem_addr;
                    w_func3 = mem_func3;
                    w_we    = mem_we;
                    if (f3_illegal(mem_func3, mem_we)) begin
                        w_state     = ST_ERR;
                        w_exc_valid = 1'b1;
                        w_exc_code  = EXC_ILLEGAL;
                        w_exc_addr  = mem_addr;
                    end else if (f3_misaligned(mem_func3, mem_addr[1:0])) begin
                        w_state     = ST_ERR;
                        w_exc_valid = 1'b1;
                        w_exc_code  = EXC_MISALIGN;
                        w_exc_addr  = mem_addr;
                    end else begin
                        w_state      = ST_BUSY;
                        w_cnt        = '0;
                        w_dbus_req   = 1'b1;
                        w_dbus_we    = mem_we ? w_be : 4'b0000;
                        w_dbus_addr  = {mem_addr[31:2], 2'b00};
                        w_dbus_wdata = w_repl;
                    end
                end
            end
            ST_BUSY: begin
                w_cnt = r_cnt + 1'b1;
                // Ready is checked first so a completion on the last cycle wins.
                if (dbus_ready) begin
                    w_state    = ST_DONE;
                    w_dbus_req = 1'b0;
                    w_dbus_we  = 4'b0000;
                    if (!r_we) begin
                        w_ld_valid = 1'b1;
                        w_ld_data  = w_aligned;
                    end
                end else if (r_cnt == c_cnt_last) begin
                    w_state     = ST_ERR;
                    w_dbus_req  = 1'b0;
                    w_dbus_we   = 4'b0000;
                    w_exc_valid = 1'b1;
                    w_exc_code  = EXC_TIMEOUT;
                    w_exc_addr  = r_addr;
                end
            end
            ST_DONE: w_state = ST_IDLE;
            ST_ERR:  w_state = ST_IDLE;
            default: w_state = ST_IDLE;
        endcase
    end

    assign stall      = ((r_state == ST_IDLE) && mem_req) || (r_state == ST_BUSY);
    assign ld_valid   = r_ld_valid;
    assign ld_data    = r_ld_data;
    assign exc_valid  = r_exc_valid;
    assign exc_code   = r_exc_code;
    assign exc_addr   = r_exc_addr;
    assign dbus_req   = r_dbus_req;
    assign dbus_we    = r_dbus_we;
    assign dbus_addr  = r_dbus_addr;
    assign dbus_wdata = r_dbus_wdata;

endmodule
`default_nettype wire

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences MEM-stage load/store requests onto a data-memory bus that has variable wait states. It generates the pipeline stall, byte enables and lane-replicated write data. It returns aligned and extended load data, and flags misaligned, illegal-width and timed-out accesses. It sits between the MEM-stage interface and the data memory, replacing the direct single-cycle dwe/daddr/dwdata path.

Parameters:
TIMEOUT, 15, max BUSY cycles waiting for dbus_ready before abort (1..255)
CNT_W, 8, width of wait-cycle counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_req  in  1  MEM stage holds a load or store this cycle
mem_we  in  1  1=store, 0=load
mem_func3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
mem_addr  in  32  byte address (ALU result)
mem_wdata  in  32  store data (rs2 value)
stall  out  1  freeze IF..MEM pipeline registers
ld_valid  out  1  one-cycle pulse, ld_data valid
ld_data  out  32  aligned, sign/zero-extended load result
exc_valid  out  1  one-cycle exception pulse
exc_code  out  2  01 misaligned, 10 illegal func3, 11 bus timeout
exc_addr  out  32  faulting byte address
dbus_req  out  1  bus request, held until accepted
dbus_we  out  4  byte write enables (0000 on loads)
dbus_addr  out  32  word address, bits[1:0]=0
dbus_wdata  out  32  lane-replicated store data
dbus_rdata  in  32  read word, valid when dbus_ready=1
dbus_ready  in  1  bus completes the access this cycle

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (rst_n). Reset forces state IDLE and clears all registered outputs: dbus_req, dbus_we, dbus_addr, dbus_wdata, ld_data, ld_valid, exc_valid, exc_code, exc_addr and the counter. A reset mid-transaction aborts it silently with no ld_valid and no exc_valid.
- States:
  - IDLE: on mem_req=1, latch addr, func3, we and wdata. Check the request:
    - illegal func3 (011, 110, 111, or store with 1xx): go to ERR, exc_code=10.
    - misaligned (H with addr[0]=1, W with addr[1:0]!=0): go to ERR, exc_code=01.
    - otherwise go to BUSY with dbus_req=1 registered.
  - BUSY: dbus_req/we/addr/wdata are held stable. The counter increments each cycle.
    - dbus_ready=1: capture dbus_rdata, deassert dbus_req, go to DONE.
    - dbus_ready=0 and counter==TIMEOUT-1: deassert dbus_req, go to ERR, exc_code=11.
    - ready on the timeout cycle: ready wins.
  - DONE: ld_valid=1 (loads only; stores give no ld_valid). stall=0. Return to IDLE.
  - ERR: exc_valid=1 and exc_addr=latched addr. stall=0. No bus cycle is issued for misaligned or illegal accesses. Return to IDLE.
- stall (combinational) = (IDLE & mem_req) | BUSY. stall is 0 in DONE and ERR, so the pipeline advances exactly once per request. mem_req is not re-sampled in DONE or ERR.
- Minimum latency: request in cycle N, bus ready in cycle N+1, DONE in cycle N+2. A zero-wait access therefore stalls 2 cycles.
- Byte enables:
  - SB: 0001<<addr[1:0]
  - SH: 0011<<addr[1:0]
  - SW: 1111
- Write data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load extraction: shift the word right by 8*addr[1:0], then apply per func3:
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- ld_data holds its value until the next load completes.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding ST_IDLE, ST_BUSY, ST_DONE, ST_ERR
  - F3_B, F3_H, F3_W, F3_BU, F3_HU
  - EXC_MISALIGN, EXC_ILLEGAL, EXC_TIMEOUT
- One combinational sub-module, dmem_load_align (func3, addr[1:0], word -> ld_data), shared with any future uncached load path.

Test Plan:
- Load LW addr=0x100, dbus_ready on the 1st BUSY cycle, rdata=0xDEADBEEF -> dbus_we=0000, dbus_addr=0x100, stall high 2 cycles, ld_valid pulse, ld_data=0xDEADBEEF.
- Store SB addr=0x203, wdata=0x000000A5 -> dbus_we=1000, dbus_wdata=0xA5A5A5A5, dbus_addr=0x200, no ld_valid.
- Load LB addr=0x101, rdata=0x00008000 -> ld_data=0xFFFFFF80. The same case with LBU -> ld_data=0x00000080.
- Misaligned LW at addr=0x102 -> dbus_req never asserts, exc_valid=1, exc_code=01, exc_addr=0x102, stall high 1 cycle.
- Timeout: dbus_ready held 0 -> dbus_req drops after 15 BUSY cycles, exc_code=11, no ld_valid. Variant with ready on the 15th cycle -> normal completion.
- rst_n low during BUSY, 3 cycles into a wait -> all outputs 0 immediately. After release, state is IDLE and a new LW completes normally.
